lc3_alu_arbiter: RTL and testbench
==================================

# lc3_alu_arbiter

Two-requester arbiter and two-stage issue pipeline that shares the single LC3 ALU between the execute stage (port 0) and the address/auxiliary unit (port 1). It accepts operations over per-port valid/ready handshakes and picks one per cycle round-robin. It drives the ALU's A/B/ALUK inputs from a registered issue stage and registers the ALU output, with LC3 condition codes and the owning requester's ID, into a back-pressurable result stage.

## Interface
- No parameters; datapath fixed at 16 bits, ALUK fixed at 2 bits.
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  synchronous reset, active-low.
- REQ0_VALID, REQ1_VALID  in  1  requester has an operation pending.
- REQ0_READY, REQ1_READY  out  1  grant; operation accepted on an edge where VALID&READY.
- REQ0_A, REQ0_B, REQ1_A, REQ1_B  in  16  operands.
- REQ0_ALUK, REQ1_ALUK  in  2  op: 0 ADD, 1 AND, 2 NOT A (B ignored), 3 OR.
- ALU_A, ALU_B  out  16  to the ALU's A and B inputs.
- ALU_ALUK  out  2  to the ALU's ALUK input.
- ALU_RESULT  in  16  combinational ALU output.
- OUT_VALID  out  1  result stage holds a result.
- OUT_READY  in  1  consumer accepts the result on an edge where OUT_VALID&OUT_READY.
- OUT_RESULT  out  16  registered result.
- OUT_NZP  out  3  {N,Z,P} of OUT_RESULT.
- OUT_ID  out  1  requester that issued the result.

## Operation
- State: issue stage S1 (valid, A, B, ALUK, ID), result stage S2 (valid, result, NZP, ID), round-robin pointer LAST (ID of the most recent grant).
- ALU_A/ALU_B/ALU_ALUK are driven directly from S1 registers. They must hold their values while S1 is stalled.
- S2 advance: S2 loads from S1 when S1.valid and (!S2.valid or OUT_READY). On an edge where S2 is emptied by the consumer and S1 is empty, S2.valid goes to 0.
- S1 accept condition: S1_free = !S1.valid or S1 advances this cycle (same-cycle pass-through, no bubble).
- Arbitration (combinational, only when S1_free):
  - Only one VALID: grant that port.
  - Both VALID: grant the port != LAST.
  - Not S1_free: both READY = 0.
- READY is never asserted to a port whose VALID is 0. At most one READY is high per cycle.
- On accept: S1 captures the operands, ALUK, and ID, and LAST is set to that ID. LAST is unchanged on cycles with no grant.
- S2 load: result = ALU_RESULT.
  - N = result[15].
  - Z = (result == 16'h0000).
  - P = !N & !Z.
  - Exactly one NZP bit is set.
- Arithmetic: ADD is modulo 2^16; carry and overflow are discarded. NOT ignores B.
- Ordering: results leave in acceptance order. No operation is dropped or duplicated under any OUT_READY pattern.

## Timing
- Reset (RESET_N = 0 at an edge):
  - S1.valid = 0, S2.valid = 0, LAST = 1 (port 0 wins the first contention).
  - OUT_VALID = 0, OUT_RESULT = 0, OUT_NZP = 3'b010, OUT_ID = 0.
  - ALU_A = 0, ALU_B = 0, ALU_ALUK = 0.
  - REQx_READY = 0 during every reset cycle.
- Reset asserted mid-operation discards in-flight S1/S2 contents with no output handshake.
- Latency: an operation accepted at edge E is in S1 during cycle E..E+1 and in S2 after edge E+1, so OUT_VALID is high in the cycle following E+1 (2 edges, no stall).
- Throughput: one operation per cycle sustained while OUT_READY = 1.
- Full condition: both S1 and S2 valid and OUT_READY = 0. Then both READY = 0 and all S1/S2 registers hold.
- When OUT_READY rises on a full pipeline, one cycle both S2 loads from S1 and S1 may accept a new request.
- Simultaneous events:
  - Same-cycle S2 drain, S1 advance, and new accept are all legal.
  - The VALID of the port not granted must be held by the requester; the arbiter keeps no memory of it except via LAST.

## Test plan
- Reset then port 0 only: ADD A=16'h7FFF, B=16'h0001 -> READY0 = 1 on the first cycle, OUT_VALID two edges later, OUT_RESULT = 16'h8000, OUT_NZP = 100, OUT_ID = 0.
- Both ports VALID continuously after reset, OUT_READY = 1 -> grants alternate 0,1,0,1. Results emerge one per cycle in the same order with matching OUT_ID.
- Port 1 AND 16'hF0F0 & 16'h0F0F -> OUT_RESULT = 0, NZP = 010. Port 0 NOT A = 16'h0000 -> 16'hFFFF, NZP = 100. OR 16'h0001 | 16'h0002 -> 16'h0003, NZP = 001.
- Stream 4 ops with OUT_READY = 0 -> exactly two accepted, then both READY = 0 and ALU_* stable. Raise OUT_READY -> all 4 results delivered in order with no loss or duplicate.
- Deassert RESET_N while S1 and S2 are both valid -> next cycle OUT_VALID = 0 and READY = 0. After release, port 0 wins contention first.

Source files
------------

// File: rtl/lc3_alu_arbiter.sv
// Round-robin arbiter sharing one LC3 ALU between two requesters, with a registered
// issue stage feeding the ALU and a back-pressurable result stage carrying NZP and owner ID.
module lc3_alu_arbiter (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [15:0] i_req0_a,
    input  logic [15:0] i_req0_b,
    input  logic [1:0]  i_req0_aluk,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [15:0] i_req1_a,
    input  logic [15:0] i_req1_b,
    input  logic [1:0]  i_req1_aluk,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [1:0]  o_alu_aluk,
    input  logic [15:0] i_alu_result,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_result,
    output logic [2:0]  o_out_nzp,
    output logic        o_out_id
);

    // Issue stage (S1)
    logic        r_s1_valid;
    logic [15:0] r_s1_a;
    logic [15:0] r_s1_b;
    logic [1:0]  r_s1_aluk;
    logic        r_s1_id;

    // Result stage (S2)
    logic        r_s2_valid;
    logic [15:0] r_s2_result;
    logic [2:0]  r_s2_nzp;
    logic        r_s2_id;

    logic        r_last;

    logic        w_s2_load;
    logic        w_s1_free;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic [15:0] w_sel_a;
    logic [15:0] w_sel_b;
    logic [1:0]  w_sel_aluk;
    logic        w_n;
    logic        w_z;
    logic [2:0]  w_nzp;

    always_comb begin
        w_s2_load = r_s1_valid && (!r_s2_valid || i_out_ready);
        w_s1_free = !r_s1_valid || w_s2_load;
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        // Grants are suppressed during reset so nothing is handshaken on a resetting edge.
        if (i_reset_n && w_s1_free) begin
            if (i_req0_valid && i_req1_valid) begin
                if (r_last) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (i_req0_valid) begin
                w_grant0 = 1'b1;
            end else if (i_req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
        w_accept   = w_grant0 || w_grant1;
        w_sel_a    = w_grant1 ? i_req1_a    : i_req0_a;
        w_sel_b    = w_grant1 ? i_req1_b    : i_req0_b;
        w_sel_aluk = w_grant1 ? i_req1_aluk : i_req0_aluk;
        w_n        = i_alu_result[15];
        w_z        = (i_alu_result == 16'h0000);
        w_nzp      = {w_n, w_z, !w_n && !w_z};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= 16'h0000;
            r_s1_b      <= 16'h0000;
            r_s1_aluk   <= 2'd0;
            r_s1_id     <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= 16'h0000;
            r_s2_nzp    <= 3'b010;
            r_s2_id     <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_s1_aluk  <= w_sel_aluk;
                r_s1_id    <= w_grant1;
                r_last     <= w_grant1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid  <= 1'b1;
                r_s2_result <= i_alu_result;
                r_s2_nzp    <= w_nzp;
                r_s2_id     <= r_s1_id;
            end else if (i_out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;
    assign o_alu_a      = r_s1_a;
    assign o_alu_b      = r_s1_b;
    assign o_alu_aluk   = r_s1_aluk;
    assign o_out_valid  = r_s2_valid;
    assign o_out_result = r_s2_result;
    assign o_out_nzp    = r_s2_nzp;
    assign o_out_id     = r_s2_id;

endmodule

// File: tb/tb_lc3_alu_arbiter.sv
// Scoreboard bench for lc3_alu_arbiter: accepted operations push their expected result,
// an output monitor pops and compares on every result handshake.
module tb_lc3_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_aluk, req1_aluk;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_aluk;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_nzp;
    logic        out_id;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [19:0] sb[$];
    logic        grant_log[$];
    logic        tb_last = 1'b1;
    logic        acc0_n = 1'b0;
    logic        acc1_n = 1'b0;

    lc3_alu_arbiter dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req0_valid(req0_valid),
        .o_req0_ready(req0_ready),
        .i_req0_a    (req0_a),
        .i_req0_b    (req0_b),
        .i_req0_aluk (req0_aluk),
        .i_req1_valid(req1_valid),
        .o_req1_ready(req1_ready),
        .i_req1_a    (req1_a),
        .i_req1_b    (req1_b),
        .i_req1_aluk (req1_aluk),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_aluk  (alu_aluk),
        .i_alu_result(alu_result),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_result(out_result),
        .o_out_nzp   (out_nzp),
        .o_out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] k);
        int unsigned s;
        case (k)
            2'd0: begin s = (int'(a) + int'(b)) % 65536; return s[15:0]; end
            2'd1: return a & b;
            2'd2: return 16'hFFFF - a;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [15:0] r);
        if ($signed(r) < 0) return 3'b100;
        if (r == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    // External ALU seen by the DUT
    assign alu_result = ref_alu(alu_a, alu_b, alu_aluk);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Input/output monitor: acceptance at the coming edge pushes, output handshake pops.
    always @(negedge clk) begin
        logic        gid;
        logic [15:0] ea, eb, er;
        logic [1:0]  ek;
        logic [19:0] exp_e;
        if (!rst_n) begin
            sb.delete();
            tb_last = 1'b1;
            acc0_n  = 1'b0;
            acc1_n  = 1'b0;
            check("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
            check("ready1_in_reset", {31'd0, req1_ready}, 32'd0);
        end else begin
            acc0_n = req0_valid & req0_ready;
            acc1_n = req1_valid & req1_ready;
            if (req0_ready & req1_ready) check("ready_both", 32'd1, 32'd0);
            if (req0_ready & !req0_valid) check("ready0_no_valid", 32'd1, 32'd0);
            if (req1_ready & !req1_valid) check("ready1_no_valid", 32'd1, 32'd0);
            if (acc0_n | acc1_n) begin
                gid = acc1_n;
                if (req0_valid && req1_valid) check("rr_grant", {31'd0, gid}, {31'd0, ~tb_last});
                tb_last = gid;
                grant_log.push_back(gid);
                ea = gid ? req1_a : req0_a;
                eb = gid ? req1_b : req0_b;
                ek = gid ? req1_aluk : req0_aluk;
                er = ref_alu(ea, eb, ek);
                sb.push_back({gid, ref_nzp(er), er});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {12'd0, out_id, out_nzp, out_result}, 32'hFFFFFFFF);
                end else begin
                    exp_e = sb.pop_front();
                    check("out_result", {16'd0, out_result}, {16'd0, exp_e[15:0]});
                    check("out_nzp", {29'd0, out_nzp}, {29'd0, exp_e[18:16]});
                    check("out_id", {31'd0, out_id}, {31'd0, exp_e[19]});
                end
            end
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int port, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] k);
        bit got = 0;
        if (port == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_aluk = k;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_aluk = k;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = (port == 0) ? acc0_n : acc1_n;
        end
        check("issue_accept", {31'd0, got}, 32'd1);
        if (port == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic drain();
        req0_valid = 0;
        req1_valid = 0;
        out_ready  = 1;
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        step();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic rand_port(input int port);
        if (port == 0) begin
            req0_valid = ($urandom_range(9) < 6);
            req0_a = 16'($urandom); req0_b = 16'($urandom); req0_aluk = 2'($urandom);
        end else begin
            req1_valid = ($urandom_range(9) < 6);
            req1_a = 16'($urandom); req1_b = 16'($urandom); req1_aluk = 2'($urandom);
        end
    endtask

    logic [15:0] ops_a[4];
    logic [15:0] ops_b[4];
    logic [1:0]  ops_k[4];

    initial begin
        int idx;
        int naccept;
        out_ready = 1; req0_a = 0; req0_b = 0; req0_aluk = 0;
        req1_a = 0; req1_b = 0; req1_aluk = 0;

        // Reset state, with both requesters asserting valid
        rst_n = 0; req0_valid = 1; req1_valid = 1;
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_out_nzp", {29'd0, out_nzp}, 32'd2);
        check("rst_out_id", {31'd0, out_id}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_alu_b", {16'd0, alu_b}, 32'd0);
        check("rst_alu_aluk", {30'd0, alu_aluk}, 32'd0);
        req0_valid = 0; req1_valid = 0; rst_n = 1;

        // Port 0 ADD overflowing into the sign bit, with latency check
        req0_valid = 1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_aluk = 2'd0;
        @(negedge clk);
        check("first_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 0;
        check("lat_e0_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_e1_out_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", {16'd0, out_result}, 32'h8000);
        check("add_nzp", {29'd0, out_nzp}, 32'd4);
        check("add_id", {31'd0, out_id}, 32'd0);
        drain();

        // Contention from reset: grants alternate starting with port 0, one per cycle
        do_reset();
        grant_log.delete();
        naccept = 0;
        rand_port(0); rand_port(1); req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            naccept += int'(acc0_n) + int'(acc1_n);
            if (acc0_n) begin rand_port(0); req0_valid = 1; end
            if (acc1_n) begin rand_port(1); req1_valid = 1; end
        end
        req0_valid = 0; req1_valid = 0;
        check("throughput", naccept, 32'd8);
        for (int i = 0; i < 4; i++) begin
            if (grant_log.size() > i) check("grant_seq", {31'd0, grant_log[i]}, i % 2);
            else check("grant_seq_missing", 32'd0, 32'd1);
        end
        drain();

        // Directed logic ops
        issue(1, 16'hF0F0, 16'h0F0F, 2'd1);
        issue(0, 16'h0000, 16'h1234, 2'd2);
        issue(0, 16'h0001, 16'h0002, 2'd3);
        issue(1, 16'hFFFF, 16'h0001, 2'd0);
        drain();

        // Back-pressure: only two accepted, ALU inputs held on the second op
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom); ops_k[i] = 2'(i);
        end
        out_ready = 0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1; req0_a = ops_a[idx]; req0_b = ops_b[idx]; req0_aluk = ops_k[idx];
            step();
            if (acc0_n) idx++;
        end
        check("stall_accepts", idx, 32'd2);
        req0_a = ops_a[idx]; req0_b = ops_b[idx]; req0_aluk = ops_k[idx];
        @(negedge clk);
        check("stall_ready0", {31'd0, req0_ready}, 32'd0);
        check("stall_alu_a", {16'd0, alu_a}, {16'd0, ops_a[1]});
        check("stall_alu_b", {16'd0, alu_b}, {16'd0, ops_b[1]});
        check("stall_alu_aluk", {30'd0, alu_aluk}, {30'd0, ops_k[1]});
        step(); step(); step();
        check("stall_hold_alu_a", {16'd0, alu_a}, {16'd0, ops_a[1]});
        out_ready = 1;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            req0_a = ops_a[idx]; req0_b = ops_b[idx]; req0_aluk = ops_k[idx];
            step();
            if (acc0_n) idx++;
        end
        check("stall_all_accepted", idx, 32'd4);
        drain();

        // Randomised traffic with random back-pressure; requesters hold until accepted
        rand_port(0); rand_port(1);
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(9) < 7);
            step();
            if (!req0_valid || acc0_n) rand_port(0);
            if (!req1_valid || acc1_n) rand_port(1);
        end
        drain();

        // Reset with a full pipeline discards everything; port 0 wins afterwards
        out_ready = 0;
        req1_valid = 0;
        req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_aluk = 2'd0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 0;
        @(negedge clk);
        check("midrst_ready0", {31'd0, req0_ready}, 32'd0);
        step();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1;
        req1_valid = 1;
        @(negedge clk);
        check("postrst_ready0", {31'd0, req0_ready}, 32'd1);
        check("postrst_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
